// File: rtl/instruction_fetch_stage_if.sv
// Fetch-stage bus: Program_Counter side (pc_in / next_pc / select_branch),
// downstream control (branch, stall, flush), imem load port and IF/ID outputs.
//   master : the surrounding pipeline / bench that drives pc_in, controls, imem writes
//   slave  : instruction_fetch_stage
`timescale 1ns/1ps
interface instruction_fetch_stage_if #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned IMEM_DEPTH = 64
);
    localparam int unsigned IDX_W = $clog2(IMEM_DEPTH);

    logic [ADDR_W-1:0] pc_in;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic              stall;
    logic              flush;
    logic              imem_we;
    logic [IDX_W-1:0]  imem_waddr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W-1:0] next_pc;
    logic              select_branch;
    logic [31:0]       instr_out;
    logic [ADDR_W-1:0] pc_out;
    logic              valid_out;
    logic              misaligned;
    logic              halted;

    modport master (
        output pc_in, branch_taken, branch_target, stall, flush,
        output imem_we, imem_waddr, imem_wdata,
        input  next_pc, select_branch, instr_out, pc_out, valid_out, misaligned, halted
    );

    modport slave (
        input  pc_in, branch_taken, branch_target, stall, flush,
        input  imem_we, imem_waddr, imem_wdata,
        output next_pc, select_branch, instr_out, pc_out, valid_out, misaligned, halted
    );
endinterface

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage sitting directly after Program_Counter.
// Reads pc_in, fetches a word from a local word-addressed imem into the IF/ID
// register and produces next_pc / select_branch (combinational) for the PC.
// FSM: IDLE (one cycle, requests RESET_PC) -> RUN -> HALT (left only by reset).
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   bus (slave)     pc_in, branch_taken/target, stall, flush, imem write port,
//                   next_pc, select_branch, instr_out, pc_out, valid_out,
//                   misaligned, halted
//   fetch_count,    present only when FETCH_STATS_EN is defined: count of
//   stall_count     valid captures and of RUN cycles stalled without a branch
`timescale 1ns/1ps
module instruction_fetch_stage #(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       IMEM_DEPTH = 64,
    parameter int unsigned       PC_STEP    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter logic [31:0]       HALT_WORD  = 32'hFFFF_FFFF
) (
    input logic                      clk,
    input logic                      rst,
    instruction_fetch_stage_if.slave bus
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]              fetch_count,
    output logic [31:0]              stall_count
`endif
);
    localparam int unsigned IDX_W = $clog2(IMEM_DEPTH);

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

    state_e state_q, state_d;

    logic [31:0]       imem [IMEM_DEPTH];
    logic [31:0]       rd_word;
    logic              capture;

    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              valid_q, valid_d;
    logic              mis_q, mis_d;

    logic [ADDR_W-1:0] next_pc;
    logic              select_branch;

    // Upper PC bits are dropped, so the memory wraps modulo IMEM_DEPTH words.
    // Misaligned PCs simply use the truncated word index.
    assign rd_word = imem[bus.pc_in[IDX_W+1:2]];
    assign capture = (state_q == StRun) && !bus.flush && !bus.branch_taken && !bus.stall;

    // Synchronous write; a same-cycle read of the written word sees the old data.
    always_ff @(posedge clk) begin
        if (bus.imem_we) begin
            imem[bus.imem_waddr] <= bus.imem_wdata;
        end
    end

    always_comb begin
        state_d       = state_q;
        next_pc       = bus.pc_in;
        select_branch = 1'b0;
        instr_d       = instr_q;
        pc_d          = pc_q;
        valid_d       = valid_q;
        mis_d         = mis_q;
        unique case (state_q)
            StIdle: begin
                next_pc       = RESET_PC;
                select_branch = 1'b1;
                state_d       = StRun;
            end
            StRun: begin
                // A branch overrides a stall.
                if (bus.branch_taken) begin
                    next_pc       = bus.branch_target;
                    select_branch = 1'b1;
                end else if (bus.stall) begin
                    next_pc = bus.pc_in;
                end else begin
                    next_pc = bus.pc_in + ADDR_W'(PC_STEP);
                end

                if (bus.flush || bus.branch_taken) begin
                    valid_d = 1'b0;
                    instr_d = '0;
                end else if (capture) begin
                    instr_d = rd_word;
                    pc_d    = bus.pc_in;
                    mis_d   = |bus.pc_in[1:0];
                    // The halt word is latched for visibility but never presented as valid.
                    if (rd_word == HALT_WORD) begin
                        valid_d = 1'b0;
                        state_d = StHalt;
                    end else begin
                        valid_d = 1'b1;
                    end
                end
            end
            StHalt: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            instr_q <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
        end
    end

    assign bus.next_pc       = next_pc;
    assign bus.select_branch = select_branch;
    assign bus.instr_out     = instr_q;
    assign bus.pc_out        = pc_q;
    assign bus.valid_out     = valid_q;
    assign bus.misaligned    = mis_q;
    assign bus.halted        = (state_q == StHalt);

`ifdef FETCH_STATS_EN
    logic fetch_inc;
    logic stall_inc;

    assign fetch_inc = capture && (rd_word != HALT_WORD);
    assign stall_inc = (state_q == StRun) && bus.stall && !bus.branch_taken;

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (fetch_inc) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (stall_inc) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_instruction_fetch_stage.sv
`timescale 1ns/1ps
module tb_instruction_fetch_stage;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DEPTH  = 64;
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam logic [31:0] HALT   = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    instruction_fetch_stage_if #(.ADDR_W(ADDR_W), .IMEM_DEPTH(DEPTH)) bus ();

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    instruction_fetch_stage #(
        .ADDR_W    (ADDR_W),
        .IMEM_DEPTH(DEPTH),
        .PC_STEP   (4),
        .RESET_PC  (32'h0),
        .HALT_WORD (HALT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus)
`ifdef FETCH_STATS_EN
        ,
        .fetch_count(fetch_count),
        .stall_count(stall_count)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 = waiting one cycle after reset, 1 = fetching, 2 = halted.
    int          m_mode = 0;
    logic [31:0] m_instr, m_pc, m_w, m_fc, m_sc;
    logic        m_valid, m_mis;
    logic [31:0] m_mem [DEPTH];
    bit          chk_en = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            m_mode = 0; m_instr = 0; m_pc = 0; m_valid = 0; m_mis = 0; m_fc = 0; m_sc = 0;
            chk_en = 1'b1;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (bus.stall && !bus.branch_taken) m_sc = m_sc + 1;
            if (bus.flush || bus.branch_taken) begin
                m_valid = 0;
                m_instr = 0;
            end else if (!bus.stall) begin
                m_w     = m_mem[(bus.pc_in / 4) % DEPTH];
                m_instr = m_w;
                m_pc    = bus.pc_in;
                m_mis   = (bus.pc_in % 4) != 0;
                if (m_w == HALT) begin
                    m_valid = 0;
                    m_mode  = 2;
                end else begin
                    m_valid = 1;
                    m_fc    = m_fc + 1;
                end
            end
        end else begin
            m_valid = 0;
        end
        if (bus.imem_we) m_mem[bus.imem_waddr] = bus.imem_wdata;
    end

    // Compare process: every cycle once a reset has been seen.
    logic [31:0] e_next;
    logic        e_sel;
    always @(negedge clk) begin
        if (chk_en) begin
            if (m_mode == 0) begin
                e_next = 32'h0; e_sel = 1;
            end else if (m_mode == 1 && bus.branch_taken) begin
                e_next = bus.branch_target; e_sel = 1;
            end else if (m_mode == 1 && !bus.stall) begin
                e_next = bus.pc_in + 32'd4; e_sel = 0;
            end else begin
                e_next = bus.pc_in; e_sel = 0;
            end
            chk("next_pc", bus.next_pc, e_next);
            chk("select_branch", {31'd0, bus.select_branch}, {31'd0, e_sel});
            chk("instr_out", bus.instr_out, m_instr);
            chk("pc_out", bus.pc_out, m_pc);
            chk("valid_out", {31'd0, bus.valid_out}, {31'd0, m_valid});
            chk("misaligned", {31'd0, bus.misaligned}, {31'd0, m_mis});
            chk("halted", {31'd0, bus.halted}, (m_mode == 2) ? 32'd1 : 32'd0);
`ifdef FETCH_STATS_EN
            chk("fetch_count", fetch_count, m_fc);
            chk("stall_count", stall_count, m_sc);
`endif
        end
    end

    // Program_Counter stand-in: when pc_loop is set, pc_in follows next_pc each edge.
    bit pc_loop = 1'b1;

    task automatic step();
        logic [31:0] nxt;
        @(negedge clk);
        nxt = bus.next_pc;
        @(posedge clk);
        #1;
        if (pc_loop) bus.pc_in = rst ? nxt : 32'd0;
        #1;
    endtask

    task automatic write_word(input int unsigned a, input logic [31:0] d);
        bus.imem_we    = 1'b1;
        bus.imem_waddr = IDX_W'(a);
        bus.imem_wdata = d;
        step();
        bus.imem_we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
    endtask

    logic [31:0] saved;

    initial begin
        bus.pc_in = 0; bus.branch_taken = 0; bus.branch_target = 0; bus.stall = 0;
        bus.flush = 0; bus.imem_we = 0; bus.imem_waddr = 0; bus.imem_wdata = 0;

        // Load imem under reset: 11,22,33,44 then 0x1000+i.
        for (int i = 0; i < DEPTH; i++) write_word(i, (i < 4) ? 32'h11 * (i + 1) : 32'h1000 + i);

        // Reset then run, plus stall.
        do_reset();
        chk("idle next_pc", bus.next_pc, 32'h0);
        chk("idle select_branch", {31'd0, bus.select_branch}, 32'd1);
        step();
        chk("first run valid", {31'd0, bus.valid_out}, 32'd0);
        step();
        chk("fetch0 instr", bus.instr_out, 32'h11);
        chk("fetch0 pc", bus.pc_out, 32'h0);
        chk("fetch0 valid", {31'd0, bus.valid_out}, 32'd1);
        step();
        chk("fetch1 instr", bus.instr_out, 32'h22);
        chk("fetch1 pc", bus.pc_out, 32'h4);
        bus.stall = 1'b1;
        #1;
        chk("stall next_pc", bus.next_pc, 32'h8);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("stall hold instr", bus.instr_out, 32'h22);
            chk("stall hold next_pc", bus.next_pc, 32'h8);
        end
        bus.stall = 1'b0;
        step();
        chk("after stall instr", bus.instr_out, 32'h33);
        chk("after stall pc", bus.pc_out, 32'h8);
        step();
        chk("fetch3 instr", bus.instr_out, 32'h44);
        chk("fetch3 pc", bus.pc_out, 32'hC);

        // Branch at pc=4.
        do_reset();
        step();
        step();
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'h20;
        #1;
        chk("branch next_pc", bus.next_pc, 32'h20);
        chk("branch select", {31'd0, bus.select_branch}, 32'd1);
        step();
        bus.branch_taken = 1'b0;
        chk("branch squash valid", {31'd0, bus.valid_out}, 32'd0);
        step();
        chk("branch target instr", bus.instr_out, 32'h1008);
        chk("branch target pc", bus.pc_out, 32'h20);
        chk("branch target valid", {31'd0, bus.valid_out}, 32'd1);

        // Halt word at imem[2].
        write_word(2, HALT);
        do_reset();
        repeat (4) step();
        chk("halt halted", {31'd0, bus.halted}, 32'd1);
        chk("halt valid", {31'd0, bus.valid_out}, 32'd0);
        chk("halt pc_out", bus.pc_out, 32'h8);
        saved = bus.next_pc;
        step();
        chk("halt next_pc steady", bus.next_pc, saved);
        rst = 1'b0;
        step();
        chk("reset clears halted", {31'd0, bus.halted}, 32'd0);
        write_word(2, 32'h33);
        rst = 1'b1;
        #1;

        // Address wrap, misalignment, adder wrap, read-during-write.
        step();
        pc_loop = 1'b0;
        bus.pc_in = 32'h100;
        step();
        chk("wrap instr", bus.instr_out, 32'h11);
        chk("wrap misaligned", {31'd0, bus.misaligned}, 32'd0);
        bus.pc_in = 32'h6;
        step();
        chk("misalign instr", bus.instr_out, 32'h22);
        chk("misalign flag", {31'd0, bus.misaligned}, 32'd1);
        chk("misalign valid", {31'd0, bus.valid_out}, 32'd1);
        bus.pc_in = 32'hFFFF_FFFC;
        #1;
        chk("pc add wrap", bus.next_pc, 32'h0);
        bus.pc_in = 32'h0;
        bus.imem_we = 1'b1; bus.imem_waddr = 0; bus.imem_wdata = 32'h5555_0000;
        step();
        bus.imem_we = 1'b0;
        chk("rdw old data", bus.instr_out, 32'h11);
        step();
        chk("rdw new data", bus.instr_out, 32'h5555_0000);
        write_word(0, 32'h11);

`ifdef FETCH_STATS_EN
        do_reset();
        pc_loop = 1'b1;
        bus.pc_in = 32'h0;
        step();
        repeat (5) step();
        bus.stall = 1'b1;
        repeat (2) step();
        bus.stall = 1'b0;
        chk("stats fetch_count", fetch_count, 32'd5);
        chk("stats stall_count", stall_count, 32'd2);
        rst = 1'b0;
        step();
        chk("stats fetch clear", fetch_count, 32'd0);
        chk("stats stall clear", stall_count, 32'd0);
        rst = 1'b1;
`endif

        // Randomised traffic, checked every cycle by the compare process.
        for (int c = 0; c < 3000; c++) begin
            rst               = ($urandom_range(0, 49) != 0);
            bus.branch_taken  = ($urandom_range(0, 7) == 0);
            bus.branch_target = $urandom;
            bus.stall         = ($urandom_range(0, 4) == 0);
            bus.flush         = ($urandom_range(0, 7) == 0);
            bus.imem_we       = ($urandom_range(0, 3) == 0);
            bus.imem_waddr    = IDX_W'($urandom);
            bus.imem_wdata    = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
            if (c % 100 == 0) pc_loop = ($urandom_range(0, 1) == 1);
            if (!pc_loop) bus.pc_in = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 511);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
